e203_csr_access_ctrl: RTL and testbench

// - Responder side of the EXU CSR access interface: accepts one CSR instruction request, performs the

---
 rtl/e203_csr_access_ctrl_if.sv | 42 ++++
 rtl/e203_csr_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_e203_csr_access_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_csr_access_ctrl_if.sv
// CSR access handshake between the EXU CSR path and the machine trap CSR block.
interface e203_csr_access_ctrl_if;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr;
    logic [1:0]  csr_req_op;
    logic [31:0] csr_req_wdata;
    logic        csr_req_wen;
    logic        priv_m;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;

    modport master (
        output csr_req_valid,
        input  csr_req_ready,
        output csr_req_addr,
        output csr_req_op,
        output csr_req_wdata,
        output csr_req_wen,
        output priv_m,
        input  csr_rsp_valid,
        output csr_rsp_ready,
        input  csr_rsp_rdata,
        input  csr_rsp_err
    );

    modport slave (
        input  csr_req_valid,
        output csr_req_ready,
        input  csr_req_addr,
        input  csr_req_op,
        input  csr_req_wdata,
        input  csr_req_wen,
        input  priv_m,
        output csr_rsp_valid,
        input  csr_rsp_ready,
        output csr_rsp_rdata,
        output csr_rsp_err
    );
endinterface

// File: rtl/e203_csr_access_ctrl.sv
// Machine trap CSR block: mtvec/mscratch/mepc read-modify-write plus read-only mhartid.
module e203_csr_access_ctrl #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HART_ID      = 32'h0,
    parameter bit          MTVEC_VEC_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    e203_csr_access_ctrl_if.slave        csr,
    output logic [31:0]                  mtvec_o,
    output logic [31:0]                  mscratch_o,
    output logic [31:0]                  mepc_o
);

    localparam logic [31:0] MTVEC_RST_VAL =
        MTVEC_VEC_EN ? MTVEC_RESET : {MTVEC_RESET[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] addr_q;
    logic [1:0]  op_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic        priv_q;

    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        sel_mtvec;
    logic        sel_mscratch;
    logic        sel_mepc;
    logic        sel_mhartid;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] mtvec_new;
    logic        err;
    logic        wr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (csr.csr_req_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (csr.csr_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        csr.csr_req_ready = (state == IDLE);
        csr.csr_rsp_valid = (state == RESP);
        csr.csr_rsp_rdata = rdata_q;
        csr.csr_rsp_err   = err_q;
    end

    assign accept = csr.csr_req_valid & csr.csr_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            priv_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= csr.csr_req_addr;
            op_q    <= csr.csr_req_op;
            wdata_q <= csr.csr_req_wdata;
            wen_q   <= csr.csr_req_wen;
            priv_q  <= csr.priv_m;
        end
    end

    always_comb begin
        sel_mtvec    = (addr_q == 12'h305);
        sel_mscratch = (addr_q == 12'h340);
        sel_mepc     = (addr_q == 12'h341);
        sel_mhartid  = (addr_q == 12'hF14);
        old_val      = 32'h0;
        unique case (1'b1)
            sel_mtvec:    old_val = mtvec_q;
            sel_mscratch: old_val = mscratch_q;
            sel_mepc:     old_val = mepc_q;
            sel_mhartid:  old_val = HART_ID;
            default:      old_val = 32'h0;
        endcase
        new_val = old_val;
        unique case (op_q)
            2'b01:   new_val = wdata_q;
            2'b10:   new_val = old_val | wdata_q;
            2'b11:   new_val = old_val & ~wdata_q;
            default: new_val = old_val;
        endcase
        err = ~(sel_mtvec | sel_mscratch | sel_mepc | sel_mhartid)
            | ~priv_q
            | (sel_mhartid & wen_q);
        wr_ok = (state == EXEC) & wen_q & (op_q != 2'b00) & ~err;
        // Reserved modes 10/11 fall back to direct mode
        mtvec_new = new_val;
        if (!MTVEC_VEC_EN || new_val[1]) mtvec_new[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_q    <= MTVEC_RST_VAL;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
        end else begin
            if (wr_ok && sel_mtvec)    mtvec_q    <= mtvec_new;
            if (wr_ok && sel_mscratch) mscratch_q <= new_val;
            if (wr_ok && sel_mepc)     mepc_q     <= {new_val[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state == EXEC) begin
            rdata_q <= err ? 32'h0 : old_val;
            err_q   <= err;
        end
    end

    assign mtvec_o    = mtvec_q;
    assign mscratch_o = mscratch_q;
    assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_e203_csr_access_ctrl.sv
// Table-driven scoreboard bench for e203_csr_access_ctrl.
module tb_e203_csr_access_ctrl;

    localparam logic [31:0] MTV_RST = 32'h2000_0041;
    localparam logic [31:0] HID     = 32'h0000_0007;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        wen;
        logic        priv;
        logic [31:0] rd;
        logic        err;
        logic [31:0] mtvec;
        logic [31:0] ms;
        logic [31:0] mepc;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mtvec_o;
    logic [31:0] mscratch_o;
    logic [31:0] mepc_o;

    int tests = 0;
    int fails = 0;

    exp_t sbq[$];
    vec_t vecs[17];

    e203_csr_access_ctrl_if bus();

    e203_csr_access_ctrl #(
        .MTVEC_RESET (MTV_RST),
        .HART_ID     (HID),
        .MTVEC_VEC_EN(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr       (bus),
        .mtvec_o   (mtvec_o),
        .mscratch_o(mscratch_o),
        .mepc_o    (mepc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({name, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({name, " rdata"}, bus.csr_rsp_rdata, e.rd);
            chk({name, " err"}, {31'd0, bus.csr_rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic drive(input vec_t v);
        bus.csr_req_valid = 1'b1;
        bus.csr_req_addr  = v.addr;
        bus.csr_req_op    = v.op;
        bus.csr_req_wdata = v.wdata;
        bus.csr_req_wen   = v.wen;
        bus.priv_m        = v.priv;
    endtask

    task automatic do_req(input vec_t v, input string name);
        exp_t e;
        int   cnt;
        int   lat;
        @(negedge clk);
        drive(v);
        cnt = 0;
        while (!bus.csr_req_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.csr_req_ready) begin
            chk({name, " accept_timeout"}, 32'd0, 32'd1);
            bus.csr_req_valid = 1'b0;
            return;
        end
        e.rd  = v.rd;
        e.err = v.err;
        sbq.push_back(e);
        @(negedge clk);
        bus.csr_req_valid = 1'b0;
        lat = 1;
        while (!bus.csr_rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 32'd2);
        if (bus.csr_rsp_valid) pop_chk(name);
        else void'(sbq.pop_front());
        chk({name, " mtvec"}, mtvec_o, v.mtvec);
        chk({name, " mscratch"}, mscratch_o, v.ms);
        chk({name, " mepc"}, mepc_o, v.mepc);
    endtask

    initial begin
        exp_t e;
        vec_t v;

        vecs[0]  = '{12'h305, 2'b00, 32'h0,         1'b0, 1'b1,
                     MTV_RST,       1'b0, MTV_RST,       32'h0,         32'h0};
        vecs[1]  = '{12'h305, 2'b01, 32'h8000_0101, 1'b1, 1'b1,
                     MTV_RST,       1'b0, 32'h8000_0101, 32'h0,         32'h0};
        vecs[2]  = '{12'h305, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1,
                     32'h8000_0101, 1'b0, 32'h8000_0101, 32'h0,         32'h0};
        vecs[3]  = '{12'h305, 2'b01, 32'h1234_567B, 1'b1, 1'b1,
                     32'h8000_0101, 1'b0, 32'h1234_5678, 32'h0,         32'h0};
        vecs[4]  = '{12'h340, 2'b01, 32'hF0F0_F0F0, 1'b1, 1'b1,
                     32'h0,         1'b0, 32'h1234_5678, 32'hF0F0_F0F0, 32'h0};
        vecs[5]  = '{12'h340, 2'b10, 32'h0000_000F, 1'b1, 1'b1,
                     32'hF0F0_F0F0, 1'b0, 32'h1234_5678, 32'hF0F0_F0FF, 32'h0};
        vecs[6]  = '{12'h340, 2'b11, 32'hF000_0000, 1'b1, 1'b1,
                     32'hF0F0_F0FF, 1'b0, 32'h1234_5678, 32'h00F0_F0FF, 32'h0};
        vecs[7]  = '{12'hF14, 2'b01, 32'h1111_1111, 1'b1, 1'b1,
                     32'h0,         1'b1, 32'h1234_5678, 32'h00F0_F0FF, 32'h0};
        vecs[8]  = '{12'hF14, 2'b00, 32'h0,         1'b0, 1'b1,
                     HID,           1'b0, 32'h1234_5678, 32'h00F0_F0FF, 32'h0};
        vecs[9]  = '{12'h7C0, 2'b00, 32'h0,         1'b0, 1'b1,
                     32'h0,         1'b1, 32'h1234_5678, 32'h00F0_F0FF, 32'h0};
        vecs[10] = '{12'h341, 2'b01, 32'h0000_1003, 1'b1, 1'b0,
                     32'h0,         1'b1, 32'h1234_5678, 32'h00F0_F0FF, 32'h0};
        vecs[11] = '{12'h341, 2'b01, 32'h0000_1003, 1'b1, 1'b1,
                     32'h0,         1'b0, 32'h1234_5678, 32'h00F0_F0FF, 32'h1002};
        vecs[12] = '{12'h341, 2'b10, 32'h0000_00FF, 1'b0, 1'b1,
                     32'h1002,      1'b0, 32'h1234_5678, 32'h00F0_F0FF, 32'h1002};
        vecs[13] = '{12'h305, 2'b00, 32'h0,         1'b0, 1'b0,
                     32'h0,         1'b1, 32'h1234_5678, 32'h00F0_F0FF, 32'h1002};
        vecs[14] = '{12'h305, 2'b11, 32'hFFFF_FFFF, 1'b1, 1'b1,
                     32'h1234_5678, 1'b0, 32'h0,         32'h00F0_F0FF, 32'h1002};
        vecs[15] = '{12'h305, 2'b01, 32'h0000_0F02, 1'b1, 1'b1,
                     32'h0,         1'b0, 32'h0000_0F00, 32'h00F0_F0FF, 32'h1002};
        vecs[16] = '{12'h305, 2'b01, 32'h0000_0F01, 1'b1, 1'b1,
                     32'h0000_0F00, 1'b0, 32'h0000_0F01, 32'h00F0_F0FF, 32'h1002};

        rst               = 1'b1;
        bus.csr_req_valid = 1'b0;
        bus.csr_req_addr  = '0;
        bus.csr_req_op    = '0;
        bus.csr_req_wdata = '0;
        bus.csr_req_wen   = 1'b0;
        bus.priv_m        = 1'b0;
        bus.csr_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst req_ready", {31'd0, bus.csr_req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, bus.csr_rsp_valid}, 32'd0);
        chk("rst rdata", bus.csr_rsp_rdata, 32'h0);
        chk("rst err", {31'd0, bus.csr_rsp_err}, 32'd0);
        chk("rst mtvec", mtvec_o, MTV_RST);
        chk("rst mscratch", mscratch_o, 32'h0);
        chk("rst mepc", mepc_o, 32'h0);

        for (int i = 0; i < 17; i++)
            do_req(vecs[i], $sformatf("v%0d", i));

        // rsp back-pressure with a second request waiting
        @(negedge clk);
        bus.csr_rsp_ready = 1'b0;
        v = '{12'h340, 2'b01, 32'hAAAA_5555, 1'b1, 1'b1,
              32'h00F0_F0FF, 1'b0, 32'h0000_0F01, 32'hAAAA_5555, 32'h1002};
        drive(v);
        chk("hold pre_ready", {31'd0, bus.csr_req_ready}, 32'd1);
        e.rd  = v.rd;
        e.err = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        bus.csr_req_addr  = 12'h340;
        bus.csr_req_op    = 2'b00;
        bus.csr_req_wdata = 32'h0;
        bus.csr_req_wen   = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d rsp_valid", k),
                {31'd0, bus.csr_rsp_valid}, 32'd1);
            chk($sformatf("hold%0d rdata", k), bus.csr_rsp_rdata, 32'h00F0_F0FF);
            chk($sformatf("hold%0d req_ready", k),
                {31'd0, bus.csr_req_ready}, 32'd0);
            @(negedge clk);
        end
        pop_chk("hold");
        chk("hold mscratch", mscratch_o, 32'hAAAA_5555);
        bus.csr_rsp_ready = 1'b1;
        @(negedge clk);
        chk("wait req_ready", {31'd0, bus.csr_req_ready}, 32'd1);
        e.rd  = 32'hAAAA_5555;
        e.err = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        bus.csr_req_valid = 1'b0;
        @(negedge clk);
        chk("wait rsp_valid", {31'd0, bus.csr_rsp_valid}, 32'd1);
        pop_chk("wait");

        // reset lands while a write sits in EXEC
        @(negedge clk);
        v = '{12'h340, 2'b01, 32'h1234_5678, 1'b1, 1'b1,
              32'h0, 1'b0, MTV_RST, 32'h0, 32'h0};
        drive(v);
        @(negedge clk);
        bus.csr_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst mscratch", mscratch_o, 32'h0);
        chk("mid_rst rsp_valid", {31'd0, bus.csr_rsp_valid}, 32'd0);
        chk("mid_rst req_ready", {31'd0, bus.csr_req_ready}, 32'd1);
        chk("mid_rst mtvec", mtvec_o, MTV_RST);
        chk("mid_rst mepc", mepc_o, 32'h0);
        v = '{12'h340, 2'b00, 32'h0, 1'b0, 1'b1,
              32'h0, 1'b0, MTV_RST, 32'h0, 32'h0};
        do_req(v, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
